// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, bubble-gated control and a forwarding tap for the hazard unit.
module exmem_pipe_reg #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned RADDR_W        = 5,
  parameter int unsigned CTRL_W         = 4,
  parameter int unsigned ZERO_REG_GUARD = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [CTRL_W-1:0]  ctrl_i,
  input  logic [DATA_W-1:0]  alu_data_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic [DATA_W-1:0]  alu_data_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0]  fwd_data_o,
  output logic [1:0]         count_o
);

  localparam int unsigned CtrlRegWrite = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  aluData;
    logic [DATA_W-1:0]  memWdata;
    logic [RADDR_W-1:0] regWaddr;
  } entry_t;

  state_t state, stateNext;
  entry_t mainQ, skidQ, inEntry;
  logic   inFire, outFire;
  logic   loadMain, loadSkid, moveSkid;
  logic   addrOk;

  assign inEntry = '{ctrl: ctrl_i, aluData: alu_data_i, memWdata: mem_wdata_i,
                     regWaddr: reg_waddr_i};

  // Handshake flags decoded from the state register only
  assign ready_o = (state != FULL);
  assign valid_o = (state != EMPTY);
  assign count_o = 2'(state);
  assign inFire  = valid_i & ready_o & ~flush_i;
  assign outFire = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadMain  = 1'b0;
    loadSkid  = 1'b0;
    moveSkid  = 1'b0;
    if (flush_i) begin
      stateNext = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (inFire) begin
            loadMain  = 1'b1;
            stateNext = ONE;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            loadMain = 1'b1;
          end else if (inFire) begin
            loadSkid  = 1'b1;
            stateNext = FULL;
          end else if (outFire) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            moveSkid  = 1'b1;
            stateNext = ONE;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  // Payload storage; flush only clears control so data paths need no extra muxing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mainQ <= '0;
      skidQ <= '0;
    end else if (flush_i) begin
      mainQ.ctrl <= '0;
      skidQ.ctrl <= '0;
    end else begin
      if (loadMain)      mainQ <= inEntry;
      else if (moveSkid) mainQ <= skidQ;
      if (loadSkid)      skidQ <= inEntry;
    end
  end

  assign ctrl_o      = valid_o ? mainQ.ctrl : '0;
  assign alu_data_o  = mainQ.aluData;
  assign mem_wdata_o = mainQ.memWdata;
  assign reg_waddr_o = mainQ.regWaddr;

  // Loads still forward; load-use stalls belong to the hazard unit
  assign addrOk      = (ZERO_REG_GUARD != 0) ? (mainQ.regWaddr != '0) : 1'b1;
  assign fwd_valid_o = valid_o & ctrl_o[CtrlRegWrite] & addrOk;
  assign fwd_addr_o  = mainQ.regWaddr;
  assign fwd_data_o  = mainQ.aluData;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_exmem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, validIn, readyIn;
  logic [3:0]  ctrlIn;
  logic [31:0] aluIn, wdIn;
  logic [4:0]  waIn;

  logic        readyO, validO, fwdV;
  logic [3:0]  ctrlO;
  logic [31:0] aluO, wdO, fwdD;
  logic [4:0]  waO, fwdA;
  logic [1:0]  cntO;

  logic        readyNg, validNg, fwdVNg;
  logic [3:0]  ctrlNg;
  logic [31:0] aluNg, wdNg, fwdDNg;
  logic [4:0]  waNg, fwdANg;
  logic [1:0]  cntNg;

  int nChecks = 0;
  int nErrors = 0;
  bit armed = 1'b0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wa;
  } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  exmem_pipe_reg #(.DATA_W(32), .RADDR_W(5), .CTRL_W(4), .ZERO_REG_GUARD(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(validIn), .ready_o(readyO),
    .ctrl_i(ctrlIn), .alu_data_i(aluIn), .mem_wdata_i(wdIn), .reg_waddr_i(waIn),
    .valid_o(validO), .ready_i(readyIn), .ctrl_o(ctrlO), .alu_data_o(aluO),
    .mem_wdata_o(wdO), .reg_waddr_o(waO), .fwd_valid_o(fwdV), .fwd_addr_o(fwdA),
    .fwd_data_o(fwdD), .count_o(cntO)
  );

  exmem_pipe_reg #(.DATA_W(32), .RADDR_W(5), .CTRL_W(4), .ZERO_REG_GUARD(0)) u_dutNg (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(validIn), .ready_o(readyNg),
    .ctrl_i(ctrlIn), .alu_data_i(aluIn), .mem_wdata_i(wdIn), .reg_waddr_i(waIn),
    .valid_o(validNg), .ready_i(readyIn), .ctrl_o(ctrlNg), .alu_data_o(aluNg),
    .mem_wdata_o(wdNg), .reg_waddr_o(waNg), .fwd_valid_o(fwdVNg), .fwd_addr_o(fwdANg),
    .fwd_data_o(fwdDNg), .count_o(cntNg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an in-order queue of at most two instructions
  always @(posedge clk) begin : model
    bit mReady, mValid, inF, outF;
    ent_t e;
    mReady = (mq.size() < 2);
    mValid = (mq.size() > 0);
    outF   = mValid && (readyIn === 1'b1);
    inF    = (validIn === 1'b1) && mReady && (flush !== 1'b1);
    if (rst === 1'b1 || flush === 1'b1) begin
      mq.delete();
    end else begin
      if (outF) void'(mq.pop_front());
      if (inF) begin
        e.ctrl = ctrlIn; e.alu = aluIn; e.wd = wdIn; e.wa = waIn;
        mq.push_back(e);
      end
    end
  end

  // Per-cycle comparison of both DUT instances against the model
  always @(negedge clk) begin : compare
    bit       eValid;
    logic [3:0] eCtrl;
    if (armed) begin
      eValid = (mq.size() > 0);
      eCtrl  = eValid ? mq[0].ctrl : 4'h0;
      chk("valid_o", 64'(validO), 64'(eValid));
      chk("ready_o", 64'(readyO), 64'(mq.size() < 2));
      chk("count_o", 64'(cntO), 64'(mq.size()));
      chk("ctrl_o", 64'(ctrlO), 64'(eCtrl));
      chk("fwd_valid_o", 64'(fwdV), 64'(eValid && eCtrl[0] && mq[0].wa != 5'd0));
      chk("ng_valid_o", 64'(validNg), 64'(eValid));
      chk("ng_fwd_valid_o", 64'(fwdVNg), 64'(eValid && eCtrl[0]));
      if (eValid) begin
        chk("alu_data_o", 64'(aluO), 64'(mq[0].alu));
        chk("mem_wdata_o", 64'(wdO), 64'(mq[0].wd));
        chk("reg_waddr_o", 64'(waO), 64'(mq[0].wa));
        chk("fwd_addr_o", 64'(fwdA), 64'(mq[0].wa));
        chk("fwd_data_o", 64'(fwdD), 64'(mq[0].alu));
        chk("ng_alu_data_o", 64'(aluNg), 64'(mq[0].alu));
      end
    end
  end

  task automatic setIn(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [4:0] w);
    validIn = v; ctrlIn = c; aluIn = a; wdIn = ~a; waIn = w;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; readyIn = 1'b0;
    setIn(1'b0, 4'h0, 32'h0, 5'd0);
    step(); step();
    rst = 1'b0;
    armed = 1'b1;

    // Reset then idle
    chk("rst_valid", 64'(validO), 64'(0));
    chk("rst_ready", 64'(readyO), 64'(1));
    chk("rst_count", 64'(cntO), 64'(0));
    chk("rst_ctrl", 64'(ctrlO), 64'(0));
    chk("rst_fwd", 64'(fwdV), 64'(0));
    chk("rst_alu", 64'(aluO), 64'(0));
    step();
    chk("idle_valid", 64'(validO), 64'(0));

    // Single transfer
    readyIn = 1'b1;
    setIn(1'b1, 4'b0001, 32'h0000_00A5, 5'd7);
    step();
    chk("st_valid", 64'(validO), 64'(1));
    chk("st_alu", 64'(aluO), 64'(32'hA5));
    chk("st_fwd", 64'(fwdV), 64'(1));
    chk("st_fwd_addr", 64'(fwdA), 64'(7));
    validIn = 1'b0;
    step();
    chk("st_idle_valid", 64'(validO), 64'(0));

    // Backpressure fills the skid, then drains A, B, C in order
    readyIn = 1'b0;
    setIn(1'b1, 4'b0101, 32'h11, 5'd3); step();
    setIn(1'b1, 4'b0101, 32'h22, 5'd4); step();
    chk("bp_count", 64'(cntO), 64'(2));
    chk("bp_ready", 64'(readyO), 64'(0));
    setIn(1'b1, 4'b0101, 32'h33, 5'd5); step();
    chk("bp_hold_count", 64'(cntO), 64'(2));
    chk("bp_hold_alu", 64'(aluO), 64'(32'h11));
    readyIn = 1'b1;
    step();
    chk("bp_b", 64'(aluO), 64'(32'h22));
    step();
    chk("bp_c", 64'(aluO), 64'(32'h33));
    chk("bp_c_count", 64'(cntO), 64'(1));
    validIn = 1'b0;
    step();
    chk("bp_empty", 64'(validO), 64'(0));

    // Streaming at one instruction per cycle
    for (int i = 1; i <= 8; i++) begin
      setIn(1'b1, 4'b1001, 32'(i), 5'(i));
      step();
      chk("stream_alu", 64'(aluO), 64'(i));
      chk("stream_count", 64'(cntO), 64'(1));
      chk("stream_ready", 64'(readyO), 64'(1));
    end
    validIn = 1'b0;
    step();

    // Flush while full with a same-cycle input
    readyIn = 1'b0;
    setIn(1'b1, 4'b1011, 32'h55, 5'd9); step();
    setIn(1'b1, 4'b1011, 32'h66, 5'd10); step();
    chk("fl_full", 64'(cntO), 64'(2));
    setIn(1'b1, 4'b1011, 32'h44, 5'd11);
    flush = 1'b1;
    step();
    chk("fl_count", 64'(cntO), 64'(0));
    chk("fl_ctrl", 64'(ctrlO), 64'(0));
    chk("fl_valid", 64'(validO), 64'(0));
    flush = 1'b0; validIn = 1'b0; readyIn = 1'b1;
    step();
    chk("fl_after_valid", 64'(validO), 64'(0));

    // Zero-register forwarding guard
    setIn(1'b1, 4'b0001, 32'h77, 5'd0);
    step();
    chk("guard_on", 64'(fwdV), 64'(0));
    chk("guard_off", 64'(fwdVNg), 64'(1));
    validIn = 1'b0;
    step();

    // Reset mid-operation together with flush
    readyIn = 1'b0;
    setIn(1'b1, 4'hF, 32'hDEAD_BEEF, 5'd21); step();
    setIn(1'b1, 4'hF, 32'hCAFE_F00D, 5'd22); step();
    rst = 1'b1; flush = 1'b1;
    step();
    chk("mrst_count", 64'(cntO), 64'(0));
    chk("mrst_ready", 64'(readyO), 64'(1));
    chk("mrst_alu", 64'(aluO), 64'(0));
    chk("mrst_wdata", 64'(wdO), 64'(0));
    chk("mrst_waddr", 64'(waO), 64'(0));
    rst = 1'b0; flush = 1'b0; validIn = 1'b0;
    step();
    chk("mrst_ready_after", 64'(readyO), 64'(1));

    // Randomized traffic with varying backpressure, flushes and resets
    for (int c = 0; c < 3000; c++) begin
      validIn = ($urandom_range(0, 3) != 0);
      readyIn = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 200) == 0);
      ctrlIn  = 4'($urandom);
      aluIn   = $urandom;
      wdIn    = $urandom;
      waIn    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step();
    end
    rst = 1'b0; flush = 1'b0; validIn = 1'b0; readyIn = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
